wt_dcache_rd_arb: RTL

- Sits directly downstream of the dcache read controllers and owns the single read port of the tag/data SRAMs.
- Arbitrates round-robin among NumPorts read controllers and issues the winning index/offset to the SRAMs.
- One cycle later it takes the winner's late-arriving tag, compares it against all ways, and returns the hit one-hot, valid bits and the hit way's data word.
- Reads stall while a higher-priority SRAM user (write buffer or miss refill) holds the port.

---
 rtl/wt_dcache_rd_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter for the dcache tag/data SRAMs: round-robin grant in cycle 0,
// tag compare and hit-way data select in cycle 1.

module wt_dcache_rd_arb_way #(
  parameter int unsigned TagWidth = 44
) (
  input  logic                rsp_vld_i,
  input  logic                way_vld_i,
  input  logic [TagWidth-1:0] way_tag_i,
  input  logic [TagWidth-1:0] cmp_tag_i,
  output logic                hit_o
);
  assign hit_o = rsp_vld_i & way_vld_i & (way_tag_i == cmp_tag_i);
endmodule

module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned SetAssoc = 8,
  parameter int unsigned TagWidth = 44,
  parameter int unsigned IdxWidth = 8,
  parameter int unsigned OffWidth = 4,
  parameter int unsigned XLen     = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                rd_req_i,
  output logic [NumPorts-1:0]                rd_ack_o,
  input  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i,
  input  logic [NumPorts-1:0][OffWidth-1:0]  rd_off_i,
  input  logic [NumPorts-1:0]                rd_tag_only_i,
  input  logic [NumPorts-1:0][TagWidth-1:0]  rd_tag_i,
  input  logic                               sram_busy_i,
  output logic                               sram_en_o,
  output logic [IdxWidth-1:0]                sram_idx_o,
  output logic [OffWidth-1:0]                sram_off_o,
  output logic                               sram_tag_only_o,
  input  logic [SetAssoc-1:0][TagWidth-1:0]  sram_rtag_i,
  input  logic [SetAssoc-1:0]                sram_rvld_i,
  input  logic [SetAssoc-1:0][XLen-1:0]      sram_rdata_i,
  output logic [NumPorts-1:0]                rd_rsp_port_oh_o,
  output logic [SetAssoc-1:0]                rd_hit_oh_o,
  output logic [SetAssoc-1:0]                rd_vld_bits_o,
  output logic [XLen-1:0]                    rd_data_o
);
  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] rsp_port_q, rsp_port_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_tag_only_q, rsp_tag_only_d;
  logic [PtrW-1:0] win;
  logic            found, gnt;

  // Scan from rr_ptr_q upward with wrap; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      int p;
      p = (int'(rr_ptr_q) + i) % int'(NumPorts);
      if (!found && rd_req_i[p]) begin
        found = 1'b1;
        win   = PtrW'(p);
      end
    end
  end

  // Grant outputs are held low during reset as well as while busy.
  assign gnt = found & ~sram_busy_i & rst_ni;

  always_comb begin
    rd_ack_o        = '0;
    sram_en_o       = gnt;
    sram_idx_o      = '0;
    sram_off_o      = '0;
    sram_tag_only_o = 1'b0;
    rr_ptr_d        = rr_ptr_q;
    rsp_vld_d       = gnt;
    rsp_port_d      = rsp_port_q;
    rsp_tag_only_d  = rsp_tag_only_q;
    if (gnt) begin
      rd_ack_o[win]   = 1'b1;
      sram_idx_o      = rd_idx_i[win];
      sram_off_o      = rd_off_i[win];
      sram_tag_only_o = rd_tag_only_i[win];
      rr_ptr_d        = (int'(win) == int'(NumPorts) - 1) ? '0 : win + 1'b1;
      rsp_port_d      = win;
      rsp_tag_only_d  = rd_tag_only_i[win];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      rsp_vld_q      <= 1'b0;
      rsp_port_q     <= '0;
      rsp_tag_only_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_port_q     <= rsp_port_d;
      rsp_tag_only_q <= rsp_tag_only_d;
    end
  end

  logic [TagWidth-1:0] cmp_tag;
  assign cmp_tag = rd_tag_i[rsp_port_q];

  for (genvar w = 0; w < int'(SetAssoc); w++) begin : g_way
    wt_dcache_rd_arb_way #(.TagWidth(TagWidth)) u_way (
      .rsp_vld_i (rsp_vld_q),
      .way_vld_i (sram_rvld_i[w]),
      .way_tag_i (sram_rtag_i[w]),
      .cmp_tag_i (cmp_tag),
      .hit_o     (rd_hit_oh_o[w])
    );
  end

  // Lowest hitting way wins the data mux when tags are corrupted into a multi-hit.
  always_comb begin
    rd_data_o        = '0;
    rd_rsp_port_oh_o = '0;
    for (int w = int'(SetAssoc) - 1; w >= 0; w--) begin
      if (rd_hit_oh_o[w]) rd_data_o = sram_rdata_i[w];
    end
    if (rsp_tag_only_q) rd_data_o = '0;
    if (rsp_vld_q) rd_rsp_port_oh_o[rsp_port_q] = 1'b1;
  end

  assign rd_vld_bits_o = rsp_vld_q ? sram_rvld_i : '0;

  a_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_ack_o));
  a_busy_no_ack: assert property (@(posedge clk_i) disable iff (!rst_ni) sram_busy_i |-> (rd_ack_o == '0));
  a_hit_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_hit_oh_o));

endmodule
